stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch datapath (BCD counter plus seven-segment driver). It synchronises and debounces four push-buttons: start, stop, clear and lap. It runs the stopwatch state machine and generates the prescaled count-increment and clear strobes for the BCD counter. It also selects whether the display shows the live count or a frozen lap value.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_if.sv | 23 ++
 rtl/stopwatch_ctrl_debounce.sv | 45 ++++
 rtl/stopwatch_ctrl.sv | 96 +++++++++
 tb/tb_stopwatch_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_STOP  = 1;
  localparam int unsigned BTN_CLEAR = 2;
  localparam int unsigned BTN_LAP   = 3;
  localparam int unsigned NUM_BTN   = 4;

  localparam logic [7:0] BCD_ZERO = 8'h00;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, datapath and display signals between the stopwatch controller and its surroundings.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [7:0] count_val;
  logic       count_inc;
  logic       count_clr;
  logic [7:0] disp_val;
  logic       running;
  logic       lap_active;

  modport master (
    output btn_start, btn_stop, btn_clear, btn_lap, count_val,
    input  count_inc, count_clr, disp_val, running, lap_active
  );

  modport slave (
    input  btn_start, btn_stop, btn_clear, btn_lap, count_val,
    output count_inc, count_clr, disp_val, running, lap_active
  );
endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// Per-button 2-FF synchroniser, counter debouncer and registered press (rising-edge) pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Counter only runs while the synchronised input disagrees with the debounced level
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, run/pause/lap FSM, tick prescaler, lap latch.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 1200000,
  parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_ctrl_if.slave sw
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level_unused;
  logic [NUM_BTN-1:0] press;

  sw_state_t     state, state_n;
  logic [PW-1:0] presc;
  logic [7:0]    lap_q;
  logic          inc_q;
  logic          clr_q;
  logic          counting;
  logic          do_clear, do_stop, do_start, do_lap;

  assign raw[BTN_START] = sw.btn_start;
  assign raw[BTN_STOP]  = sw.btn_stop;
  assign raw[BTN_CLEAR] = sw.btn_clear;
  assign raw[BTN_LAP]   = sw.btn_lap;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[g]),
      .level(level_unused[g]),
      .press(press[g])
    );
  end

  // Only the highest-priority press of a cycle is acted on
  assign do_clear = press[BTN_CLEAR];
  assign do_stop  = press[BTN_STOP]  & ~do_clear;
  assign do_start = press[BTN_START] & ~do_clear & ~press[BTN_STOP];
  assign do_lap   = press[BTN_LAP]   & ~do_clear & ~press[BTN_STOP] & ~press[BTN_START];

  assign counting = (state == RUN) || (state == LAP);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (do_start) state_n = RUN;
      RUN:     if (do_stop) state_n = PAUSE;
               else if (do_lap) state_n = LAP;
      LAP:     if (do_stop) state_n = PAUSE;
               else if (do_lap) state_n = RUN;
      PAUSE:   if (do_start) state_n = RUN;
      default: state_n = IDLE;
    endcase
    if (do_clear) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      presc <= '0;
      lap_q <= BCD_ZERO;
      inc_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      state <= state_n;
      clr_q <= do_clear;
      if (do_clear) begin
        presc <= '0;
        lap_q <= BCD_ZERO;
        inc_q <= 1'b0;
      end else begin
        inc_q <= counting && (presc == PRESC_LAST);
        // PAUSE simply stops advancing, so a resumed run keeps its partial tick
        if (counting) presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        if (state == RUN && do_lap) lap_q <= sw.count_val;
      end
    end
  end

  assign sw.count_inc  = inc_q;
  assign sw.count_clr  = clr_q;
  assign sw.running    = counting;
  assign sw.lap_active = (state == LAP);
  assign sw.disp_val   = (state == LAP) ? lap_q : sw.count_val;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised self-checking bench for stopwatch_ctrl with a BCD datapath model and reference model.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int TICK = 10;
  localparam int DEB  = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw_b = '0;
  logic [7:0] dp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl_if sw ();

  assign sw.btn_start = raw_b[BTN_START];
  assign sw.btn_stop  = raw_b[BTN_STOP];
  assign sw.btn_clear = raw_b[BTN_CLEAR];
  assign sw.btn_lap   = raw_b[BTN_LAP];
  assign sw.count_val = dp;

  stopwatch_ctrl #(
    .TICK_DIV       (TICK),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw)
  );

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    int d;
    d = (int'(v[7:4]) * 10 + int'(v[3:0]) + 1) % 100;
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  // Datapath: BCD counter driven by the controller strobes
  always @(posedge clk) begin
    if (!rst_n)             dp <= 8'h00;
    else if (sw.count_clr)  dp <= 8'h00;
    else if (sw.count_inc)  dp <= bcd_inc(dp);
  end

  // Reference model
  int             m_state = S_IDLE;
  int             m_presc = 0;
  logic [7:0]     m_latch = 8'h00;
  bit             m_inc = 1'b0, m_clr = 1'b0;
  bit [3:0]       m_press = '0, m_rose = '0, m_r1 = '0, m_r2 = '0, m_lvl = '0;
  logic [DEB-1:0] hist [4];
  int             hn [4];

  always @(posedge clk) begin
    bit smp, tog, cur_run;
    if (!rst_n) begin
      m_state = S_IDLE; m_presc = 0; m_latch = 8'h00; m_inc = 0; m_clr = 0;
      m_press = '0; m_rose = '0; m_r1 = '0; m_r2 = '0; m_lvl = '0;
      for (int i = 0; i < 4; i++) begin hist[i] = '0; hn[i] = 0; end
    end else begin
      cur_run = (m_state == S_RUN) || (m_state == S_LAP);
      m_clr = m_press[BTN_CLEAR];
      m_inc = 1'b0;
      if (m_press[BTN_CLEAR]) begin
        m_state = S_IDLE; m_presc = 0; m_latch = 8'h00;
      end else begin
        if (cur_run) begin
          m_presc++;
          if (m_presc == TICK) begin m_presc = 0; m_inc = 1'b1; end
        end
        if (m_press[BTN_STOP]) begin
          if (cur_run) m_state = S_PAUSE;
        end else if (m_press[BTN_START]) begin
          if (m_state == S_IDLE || m_state == S_PAUSE) m_state = S_RUN;
        end else if (m_press[BTN_LAP]) begin
          if (m_state == S_RUN) begin m_state = S_LAP; m_latch = dp; end
          else if (m_state == S_LAP) m_state = S_RUN;
        end
      end
      // Debounced level flips once the last DEB synchronised samples all disagree with it
      for (int i = 0; i < 4; i++) begin
        smp = m_r2[i]; m_r2[i] = m_r1[i]; m_r1[i] = raw_b[i];
        hist[i] = (hist[i] << 1) | DEB'(smp);
        if (hn[i] < DEB) hn[i]++;
        tog = (hn[i] == DEB) && (hist[i] == {DEB{~m_lvl[i]}});
        if (tog) m_lvl[i] = ~m_lvl[i];
        m_press[i] = m_rose[i];
        m_rose[i]  = tog && m_lvl[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("count_inc", 32'(sw.count_inc), 32'(m_inc));
    check("count_clr", 32'(sw.count_clr), 32'(m_clr));
    check("running", 32'(sw.running), 32'(m_state == S_RUN || m_state == S_LAP));
    check("lap_active", 32'(sw.lap_active), 32'(m_state == S_LAP));
    check("disp_val", 32'(sw.disp_val), 32'((m_state == S_LAP) ? m_latch : dp));
    check("not_both", 32'(sw.count_inc & sw.count_clr), 32'(0));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int btn, input int hold);
    raw_b[btn] = 1'b1;
    cycles(hold);
    raw_b[btn] = 1'b0;
  endtask

  task automatic wait_count(input logic [7:0] target, input string tag);
    int n;
    n = 0;
    while (dp !== target && n < 3000) begin @(negedge clk); n++; end
    check(tag, 32'(dp), 32'(target));
  endtask

  initial begin
    int n;
    cycles(3);
    check("reset_inc", 32'(sw.count_inc), 32'(0));
    check("reset_run", 32'(sw.running), 32'(0));
    check("reset_disp", 32'(sw.disp_val), 32'(8'h00));
    rst_n = 1'b1;

    // start held: state changes one cycle after the press pulse
    raw_b[BTN_START] = 1'b1;
    n = 0;
    while (!sw.running && n < 50) begin @(negedge clk); n++; end
    check("start_latency", 32'(n), 32'(2 + DEB + 1 + 1));
    cycles(2);
    raw_b[BTN_START] = 1'b0;
    cycles(32);
    check("count_after_30", 32'(dp), 32'(8'h03));

    // glitch on stop is filtered, clean stop pauses, start resumes
    tap(BTN_STOP, 2);
    cycles(12);
    check("glitch_running", 32'(sw.running), 32'(1));
    tap(BTN_STOP, 8);
    cycles(20);
    check("paused", 32'(sw.running), 32'(0));
    tap(BTN_START, 8);
    cycles(40);

    // lap freezes the display while counting continues
    wait_count(8'h12, "reach_12");
    tap(BTN_LAP, 8);
    cycles(2);
    check("lap_on", 32'(sw.lap_active), 32'(1));
    wait_count(8'h15, "reach_15");
    check("lap_frozen", 32'(sw.disp_val != dp), 32'(1));
    tap(BTN_LAP, 8);
    cycles(3);
    check("lap_release", 32'(sw.disp_val), 32'(dp));

    // clear and start debounced together: clear wins
    raw_b[BTN_CLEAR] = 1'b1; raw_b[BTN_START] = 1'b1;
    cycles(8);
    raw_b = '0;
    cycles(5);
    check("clr_wins_run", 32'(sw.running), 32'(0));
    check("clr_wins_cnt", 32'(dp), 32'(8'h00));

    // run through the 99 -> 00 wrap
    tap(BTN_START, 8);
    wait_count(8'h99, "reach_99");
    wait_count(8'h00, "wrap_00");
    check("wrap_running", 32'(sw.running), 32'(1));

    // reset mid-count while in LAP
    tap(BTN_LAP, 8);
    cycles(5);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    check("rst_running", 32'(sw.running), 32'(0));
    check("rst_lap", 32'(sw.lap_active), 32'(0));
    check("rst_disp", 32'(sw.disp_val), 32'(8'h00));
    cycles(30);
    check("rst_no_inc_cnt", 32'(dp), 32'(8'h00));

    // randomised button traffic with occasional resets
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        cycles($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      raw_b = 4'($urandom_range(1, 15) & (($urandom_range(0, 3) == 0) ? 15 : (1 << $urandom_range(0, 3))));
      if ($urandom_range(0, 7) == 0) raw_b[BTN_CLEAR] = 1'b0;
      cycles($urandom_range(1, 10));
      raw_b = '0;
      cycles($urandom_range(0, 40));
    end

    cycles(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
